// File: rtl/port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// port_arbiter_pkg
// Shared types and constants for the three-requester round-robin arbiter.
//   state_e        : arbiter FSM state (IDLE, GRANT, RELEASE)
//   OWNER_*        : encoded owner values, OWNER_NONE when nothing is granted
//   HOLD_W         : width of the hold and wait counters
//   owner_to_gnt() : encoded owner -> one-hot grant vector
// ----------------------------------------------------------------------------
package port_arbiter_pkg;

   localparam int HOLD_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam logic [1:0] OWNER_A    = 2'd0;
   localparam logic [1:0] OWNER_B    = 2'd1;
   localparam logic [1:0] OWNER_C    = 2'd2;
   localparam logic [1:0] OWNER_NONE = 2'd3;

   function automatic logic [2:0] owner_to_gnt(input logic [1:0] owner_val);
      logic [2:0] onehot;
      case (owner_val)
         OWNER_A: onehot = 3'b001;
         OWNER_B: onehot = 3'b010;
         OWNER_C: onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/port_arbiter_pick.sv
// ----------------------------------------------------------------------------
// port_arbiter_pick
// Combinational round-robin selector. The search starts at the requester after
// the previous owner and wraps around, so the previous owner is chosen again
// only when nobody else is requesting.
// Ports:
//   req  [2:0] in  : request vector, bit i = requester i
//   last [1:0] in  : previous owner (OWNER_NONE searches from A)
//   pick [1:0] out : selected owner, OWNER_NONE when no request
//   any        out : at least one request present
// ----------------------------------------------------------------------------
module port_arbiter_pick
   import port_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] pick,
   output logic       any
);

   always_comb begin
      any  = |req;
      pick = OWNER_NONE;
      case (last)
         OWNER_A: begin
            if (req[1])      pick = OWNER_B;
            else if (req[2]) pick = OWNER_C;
            else if (req[0]) pick = OWNER_A;
         end
         OWNER_B: begin
            if (req[2])      pick = OWNER_C;
            else if (req[0]) pick = OWNER_A;
            else if (req[1]) pick = OWNER_B;
         end
         default: begin
            if (req[0])      pick = OWNER_A;
            else if (req[1]) pick = OWNER_B;
            else if (req[2]) pick = OWNER_C;
         end
      endcase
   end

endmodule

// File: rtl/port_arbiter.sv
// ----------------------------------------------------------------------------
// port_arbiter
// Three-requester round-robin arbiter with a bounded hold time. An owner keeps
// the grant for at most HOLD_CYCLES cycles, and every grant is followed by one
// RELEASE cycle with no owner before the next pick.
//
// Parameter:
//   HOLD_CYCLES      : max consecutive grant cycles per owner (1..15)
// Ports:
//   clk              in  : clock, rising edge
//   rst_n            in  : asynchronous active-low reset
//   req_a/req_b/req_c in : requests from A (0), B (1), C (2)
//   done             in  : owner releases early; ignored with no grant
//   gnt      [2:0]   out : one-hot grant
//   owner    [1:0]   out : encoded owner, 3 = none
//   busy             out : high in GRANT and RELEASE
//   hold_cnt [3:0]   out : grant cycles remaining after the current one
//   max_wait [3:0]   out : only with PORT_ARBITER_WAIT_CNT_EN defined; longest
//                          run of cycles any requester waited, saturating at 15
//
// All outputs come straight from flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner, waiting for any request
// GRANT   | owner holds the grant, hold counter running down
// RELEASE | single gap cycle, no owner; re-pick or fall back to IDLE
// ----------------------------------------------------------------------------
module port_arbiter
   import port_arbiter_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              req_c,
   input  logic              done,
   output logic [2:0]        gnt,
   output logic [1:0]        owner,
   output logic              busy,
   output logic [HOLD_W-1:0] hold_cnt
`ifdef PORT_ARBITER_WAIT_CNT_EN
   ,
   output logic [HOLD_W-1:0] max_wait
`endif
);

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   state_e            state_q, state_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        last_q, last_d;
   logic              busy_q, busy_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic [2:0]        req_vec;
   logic [1:0]        pick;
   logic              any_req;
   logic              owner_req;
   logic              grant_new;

   assign req_vec = {req_c, req_b, req_a};

   port_arbiter_pick u_pick (
      .req  (req_vec),
      .last (last_q),
      .pick (pick),
      .any  (any_req)
   );

   always_comb begin
      case (owner_q)
         OWNER_A: owner_req = req_a;
         OWNER_B: owner_req = req_b;
         OWNER_C: owner_req = req_c;
         default: owner_req = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      last_d    = last_q;
      busy_d    = busy_q;
      hold_d    = hold_q;
      grant_new = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) grant_new = 1'b1;
         end
         GRANT: begin
            // Any combination of release causes leads to a single RELEASE cycle.
            if (done || !owner_req || (hold_q == '0)) begin
               state_d = RELEASE;
               gnt_d   = 3'b000;
               owner_d = OWNER_NONE;
               hold_d  = '0;
               busy_d  = 1'b1;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         RELEASE: begin
            if (any_req) begin
               grant_new = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            owner_d = OWNER_NONE;
            hold_d  = '0;
            busy_d  = 1'b0;
         end
      endcase

      if (grant_new) begin
         state_d = GRANT;
         gnt_d   = owner_to_gnt(pick);
         owner_d = pick;
         last_d  = pick;
         hold_d  = HOLD_LOAD;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 3'b000;
         owner_q <= OWNER_NONE;
         last_q  <= OWNER_C;
         busy_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt      = gnt_q;
   assign owner    = owner_q;
   assign busy     = busy_q;
   assign hold_cnt = hold_q;

`ifdef PORT_ARBITER_WAIT_CNT_EN
   // A cycle counts as waiting only while the arbiter is busy with someone
   // else; the single IDLE sampling cycle is normal grant latency.
   logic [HOLD_W-1:0] wait_q [3];
   logic [HOLD_W-1:0] wait_d [3];
   logic [HOLD_W-1:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      for (int i = 0; i < 3; i++) begin
         wait_d[i] = wait_q[i];
         if (!req_vec[i] || gnt_q[i]) begin
            wait_d[i] = '0;
         end else if (busy_q && (wait_q[i] != '1)) begin
            wait_d[i] = wait_q[i] + 1'b1;
         end
         if (wait_d[i] > max_d) max_d = wait_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) wait_q[i] <= '0;
         max_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) wait_q[i] <= wait_d[i];
         max_q <= max_d;
      end
   end

   assign max_wait = max_q;
`endif

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: maximum consecutive cycles one requester holds the grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_a  input  1  request from requester A (index 0).
REQ-005 req_b  input  1  request from requester B (index 1).
REQ-006 req_c  input  1  request from requester C (index 2).
REQ-007 done  input  1  current owner releases early; ignored when no grant is active.
REQ-008 gnt  output  3  one-hot grant, bit i = requester i; never more than one bit set.
REQ-009 owner  output  2  encoded owner: 0=A, 1=B, 2=C, 3=none.
REQ-010 busy  output  1  high in GRANT and RELEASE states.
REQ-011 hold_cnt  output  4  remaining grant cycles after the current one; 0 outside GRANT.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-013 IDLE: no request -> stay; any request -> GRANT next cycle; grant appears in the cycle after the request is sampled (1-cycle latency).
REQ-014 Selection SHALL be round-robin: search order starts at index last+1 mod 3; last updates to the new owner on every grant.
REQ-015 On entry to GRANT, hold_cnt SHALL load HOLD_CYCLES-1, then decrement by 1 each GRANT cycle, stopping at 0.
REQ-016 GRANT exits to RELEASE when any of these holds: done=1, owner's req=0, or hold_cnt=0. Simultaneous conditions SHALL cause one release.
REQ-017 RELEASE lasts exactly one cycle with gnt=0 and owner=3. It then goes to GRANT with a fresh pick if any req=1, else to IDLE.
REQ-018 A requester still requesting after expiry SHALL be re-granted only if no other requester is pending (round-robin fairness).
REQ-019 HOLD_CYCLES=1: grant SHALL last exactly one cycle, with hold_cnt=0 throughout.
REQ-020 gnt, owner, busy and hold_cnt SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-021 Asserting rst_n low SHALL force, without waiting for a clock: state=IDLE, gnt=0, owner=3, busy=0, hold_cnt=0, last=2, so A has first priority.
REQ-022 Reset asserted mid-grant SHALL drop gnt immediately; after rst_n deasserts, operation resumes from IDLE at the next edge.

Configuration
REQ-023 Macro PORT_ARBITER_WAIT_CNT_EN defined: adds output max_wait[3:0].
- max_wait holds the largest number of consecutive cycles any requester waited with req=1 and no gnt.
- The value saturates at 15 and resets to 0.
REQ-024 Macro not defined: port max_wait and its counters SHALL be absent; all other behaviour is unchanged.

Structure
REQ-025 Package port_arbiter_pkg SHALL hold:
- the state enum (IDLE, GRANT, RELEASE);
- owner encoding constants OWNER_A/B/C/NONE;
- constant HOLD_W=4.
REQ-026 Round-robin selection SHALL be a combinational sub-module port_arbiter_pick.
- Inputs: req[2:0], last[1:0].
- Outputs: pick[1:0], any.

Verification
REQ-027 Reset, then req_a=1 held, HOLD_CYCLES=4 -> gnt=001 for cycles 2..5, hold_cnt 3,2,1,0, RELEASE at cycle 6, re-grant to A at cycle 7.
REQ-028 req_a=req_b=req_c=1 held -> grant order A,B,C,A, each block 4 cycles, separated by one RELEASE cycle.
REQ-029 A granted, done=1 on second grant cycle -> RELEASE next cycle; with req_b=1 pending, B granted the following cycle.
REQ-030 A granted, rst_n=0 mid-grant -> gnt=000, owner=3 and busy=0 before the next clk edge; after release with req_c=1, C granted within 2 cycles.
REQ-031 HOLD_CYCLES=1, req_a=req_b=1 -> gnt alternates 001,000,010,000,001.
REQ-032 With PORT_ARBITER_WAIT_CNT_EN, req_a=req_b=req_c=1, HOLD_CYCLES=4 -> max_wait reaches 10 for C's first wait.
